fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined processor. It owns the program counter and drives the instruction-port address of the 32x20 main memory. It captures the combinationally-read instruction word into the IF/ID register. It honours stall and redirect requests from downstream stages and stops fetching at the end of the code region.

Parameters:
ADDR_W, 5, memory address / PC width
INSTR_W, 20, instruction word width
RESET_PC, 0, first fetch address after start
LAST_PC, 27, last code address; words above it are data (28..31)

Ports:
Clock  in  1  rising-edge clock
Resetn  in  1  asynchronous reset, active-low
start_i  in  1  single-cycle pulse; begin fetching from RESET_PC
stall_i  in  1  decode not ready; hold PC and IF/ID
redirect_i  in  1  branch/jump taken; squash and refetch
redirect_pc_i  in  ADDR_W  redirect target
imem_addr_o  out  ADDR_W  to memory instruction-port address
imem_q_i  in  INSTR_W  instruction word from memory (combinational read)
if_instr_o  out  INSTR_W  IF/ID instruction
if_pc_o  out  ADDR_W  IF/ID address of if_instr_o
if_valid_o  out  1  IF/ID holds a real instruction
running_o  out  1  state == RUN
done_o  out  1  state == DONE

Behaviour:
- Reset (Resetn low, async):
  - state = IDLE, pc = RESET_PC
  - if_instr_o = 0, if_pc_o = 0, if_valid_o = 0
  - running_o = 0, done_o = 0
  - Releasing Resetn mid-program always returns to IDLE.
- imem_addr_o = pc, combinational from the pc register.
- States: IDLE, RUN, DONE. Encoding is 2 bits, declared in the package.
- IDLE:
  - start_i -> RUN, with pc = RESET_PC.
  - stall_i and redirect_i are ignored.
  - if_valid_o = 0.
- RUN, no redirect, stall_i = 0:
  - IF/ID <= {imem_q_i, pc}, if_valid_o <= 1.
  - pc <= pc + 1, wrapping modulo 2^ADDR_W.
  - If pc == LAST_PC, the capture still occurs and state -> DONE.
- RUN, stall_i = 1: pc, IF/ID and if_valid_o all hold. No state change.
- Latency: the word at address A appears on if_instr_o on the clock edge that ends the cycle where pc == A and stall_i = 0. Sustained throughput is one instruction per clock.
- redirect_i = 1 in RUN or DONE (takes priority over stall_i):
  - pc <= redirect_pc_i, if_valid_o <= 0 (one-cycle bubble); if_instr_o and if_pc_o are don't-care.
  - state -> RUN if redirect_pc_i <= LAST_PC, else -> DONE.
- DONE:
  - No new capture.
  - stall_i = 0 -> if_valid_o <= 0. stall_i = 1 -> the last instruction is held.
  - start_i is ignored; only redirect_i or reset leaves DONE.
- start_i in RUN or DONE: ignored.
- Simultaneous start_i and redirect_i in IDLE: start wins, redirect is ignored.
- Width rules: pc arithmetic is unsigned ADDR_W. redirect_pc_i is taken verbatim.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds output fetch_cnt_o [15:0]: increments on each RUN capture.
  - Adds output stall_cnt_o [15:0]: increments on each RUN cycle with stall_i = 1 and no redirect.
  - Both counters saturate at 16'hFFFF and reset to 0 on Resetn.
  - Both also clear on start_i accepted in IDLE.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Shared package/include holds:
  - ADDR_W and INSTR_W defaults
  - state encodings ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - instruction field positions: opcode [19:16], rd [15:12], rs [11:8], rt [7:4], imm5 [4:0]
- One natural sub-module: fetch_perf_cnt, the pair of saturating counters, instantiated only under FETCH_PERF_CNT_EN.
- The PC, FSM and IF/ID register stay in fetch_stage.

Test Plan:
1. Memory words 0..2 = 20'hF001C, 20'hF101E, 20'hF201F; pulse start_i, no stall -> if_instr_o shows F001C/F101E/F201F with if_pc_o 0/1/2 on three consecutive edges, if_valid_o = 1.
2. stall_i high for 3 cycles while if_pc_o = 1 -> if_instr_o holds 20'hF101E, imem_addr_o holds 2, then resumes at pc 2 with no skipped or duplicated word.
3. redirect_i with redirect_pc_i = 8 while stall_i = 1 at pc 4 -> next edge if_valid_o = 0, imem_addr_o = 8; following edge if_pc_o = 8 with the word at address 8.
4. Run to LAST_PC = 27 -> capture at pc 27, done_o = 1, the next edge gives if_valid_o = 0, and imem_addr_o never feeds 28 into IF/ID. A later redirect_pc_i = 3 returns to RUN. A later redirect_pc_i = 30 goes straight to DONE.
5. Assert Resetn low mid-RUN at pc 12 -> immediately state = IDLE, if_valid_o = 0, imem_addr_o = 0. start_i is required to refetch from 0.
6. With FETCH_PERF_CNT_EN: 10 fetches plus 4 stall cycles -> fetch_cnt_o = 10, stall_cnt_o = 4. Forcing 70000 stall cycles -> stall_cnt_o = 16'hFFFF.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared widths, FSM state encoding and instruction field positions for the fetch stage.
package fetch_stage_pkg;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned INSTR_W = 20;
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;

  // Instruction field positions (msb/lsb); imm5 overlaps the low bit of rt.
  localparam int unsigned OPC_MSB  = 19;
  localparam int unsigned OPC_LSB  = 16;
  localparam int unsigned RD_MSB   = 15;
  localparam int unsigned RD_LSB   = 12;
  localparam int unsigned RS_MSB   = 11;
  localparam int unsigned RS_LSB   = 8;
  localparam int unsigned RT_MSB   = 7;
  localparam int unsigned RT_LSB   = 4;
  localparam int unsigned IMM5_MSB = 4;
  localparam int unsigned IMM5_LSB = 0;

  function automatic logic [3:0] instr_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating fetch and stall event counters for the fetch stage.
module fetch_perf_cnt
  import fetch_stage_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             fetch_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (clr) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc && (fetch_cnt != CNT_MAX)) fetch_cnt <= fetch_cnt + CNT_W'(1);
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction port and fills IF/ID.
// Optional perf counters are enabled with FETCH_PERF_CNT_EN.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(27)
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               start_i,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_q_i,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic [ADDR_W-1:0]  if_pc_o,
  output logic               if_valid_o,
  output logic               running_o,
  output logic               done_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   fetch_cnt_o,
  output logic [CNT_W-1:0]   stall_cnt_o
`endif
);

  fetch_state_t       state, state_nx;
  logic [ADDR_W-1:0]  pc, pc_nx;
  logic [INSTR_W-1:0] instr_nx;
  logic [ADDR_W-1:0]  if_pc_nx;
  logic               valid_nx;

  assign imem_addr_o = pc;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      if_instr_o <= '0;
      if_pc_o    <= '0;
      if_valid_o <= 1'b0;
      running_o  <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      if_instr_o <= instr_nx;
      if_pc_o    <= if_pc_nx;
      if_valid_o <= valid_nx;
      running_o  <= (state_nx == ST_RUN);
      done_o     <= (state_nx == ST_DONE);
    end
  end

  // Redirect outranks stall in RUN and DONE; IDLE only listens to start.
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    instr_nx = if_instr_o;
    if_pc_nx = if_pc_o;
    valid_nx = if_valid_o;
    unique case (state)
      ST_IDLE: begin
        valid_nx = 1'b0;
        if (start_i) begin
          state_nx = ST_RUN;
          pc_nx    = RESET_PC;
        end
      end
      ST_RUN: begin
        if (redirect_i) begin
          pc_nx    = redirect_pc_i;
          valid_nx = 1'b0;
          state_nx = (redirect_pc_i <= LAST_PC) ? ST_RUN : ST_DONE;
        end else if (!stall_i) begin
          instr_nx = imem_q_i;
          if_pc_nx = pc;
          valid_nx = 1'b1;
          pc_nx    = ADDR_W'(pc + ADDR_W'(1));
          if (pc == LAST_PC) state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        if (redirect_i) begin
          pc_nx    = redirect_pc_i;
          valid_nx = 1'b0;
          state_nx = (redirect_pc_i <= LAST_PC) ? ST_RUN : ST_DONE;
        end else if (!stall_i) begin
          valid_nx = 1'b0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic cnt_clr, cnt_fetch, cnt_stall;

  assign cnt_clr   = (state == ST_IDLE) && start_i;
  assign cnt_fetch = (state == ST_RUN) && !redirect_i && !stall_i;
  assign cnt_stall = (state == ST_RUN) && !redirect_i && stall_i;

  fetch_perf_cnt u_perf (
    .clk       (Clock),
    .rst_n     (Resetn),
    .clr       (cnt_clr),
    .fetch_inc (cnt_fetch),
    .stall_inc (cnt_stall),
    .fetch_cnt (fetch_cnt_o),
    .stall_cnt (stall_cnt_o)
  );
`endif

endmodule
